// File: rtl/uart_fifo_link_if.sv
// Host-side handshake bundle for uart_fifo_link: TX push and RX pop channels.
`timescale 1ns/1ps
interface uart_fifo_link_if #(
    parameter int unsigned DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;

    modport master (
        output tx_data, output tx_valid, input  tx_ready,
        input  rx_data, input  rx_valid, output rx_ready
    );
    modport slave (
        input  tx_data, input  tx_valid, output tx_ready,
        output rx_data, output rx_valid, input  rx_ready
    );
endinterface

// File: rtl/uart_fifo_link.sv
// Full-duplex UART with selectable baud rate, FIFO-buffered TX and RX,
// optional parity, sticky parity/frame/overrun flags.
`timescale 1ns/1ps

// First-word-fall-through FIFO; pointers carry one extra wrap bit.
module uart_fifo_link_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Read/write pointer advance
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage write; contents are don't-care until pushed
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end
endmodule

module uart_fifo_link #(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [2:0]             baud_sel,
    uart_fifo_link_if.slave        link,
    output logic                   txd,
    output logic                   tx_busy,
    input  logic                   rxd,
    output logic                   parity_err,
    output logic                   frame_err,
    output logic                   overrun,
    input  logic                   err_clr
);
    localparam int unsigned MAX_DIV = CLK_HZ / 2400;
    localparam int unsigned CNT_W   = $clog2(STOP_BITS * MAX_DIV + 1);
    localparam int unsigned IDX_W   = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK} rx_state_t;

    function automatic logic [CNT_W-1:0] baud_div(input logic [2:0] sel);
        case (sel)
            3'd0:    return CNT_W'(CLK_HZ / 2400);
            3'd1:    return CNT_W'(CLK_HZ / 4800);
            3'd2:    return CNT_W'(CLK_HZ / 9600);
            3'd3:    return CNT_W'(CLK_HZ / 19200);
            3'd4:    return CNT_W'(CLK_HZ / 38400);
            3'd5:    return CNT_W'(CLK_HZ / 57600);
            3'd6:    return CNT_W'(CLK_HZ / 115200);
            default: return CNT_W'(CLK_HZ / 230400);
        endcase
    endfunction

    // Expected parity bit for a data word (odd=1, even=2)
    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        return (PARITY == 1) ? ~^d : ^d;
    endfunction

    logic [CNT_W-1:0] cur_div;
    assign cur_div = baud_div(baud_sel);

    // ---------------- TX path ----------------
    tx_state_t            tx_state, tx_next;
    logic [CNT_W-1:0]     tx_cnt, tx_bit_end, tx_stop_end;
    logic [IDX_W-1:0]     tx_idx;
    logic [DATA_BITS-1:0] tx_shift, tx_head;
    logic                 tx_par, tx_pop, tx_push, tx_wrap, tx_empty, tx_full;

    assign tx_push       = link.tx_valid && !tx_full;
    assign link.tx_ready = !tx_full;
    assign tx_busy       = (tx_state != TX_IDLE) || !tx_empty;

    uart_fifo_link_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) tx_fifo (
        .clk(clk), .reset(reset), .push(tx_push), .push_data(link.tx_data),
        .pop(tx_pop), .head(tx_head), .empty(tx_empty), .full(tx_full)
    );

    // TX state register
    always_ff @(posedge clk) begin
        if (reset) tx_state <= TX_IDLE;
        else       tx_state <= tx_next;
    end

    // TX next state, FIFO pop and serial line level
    always_comb begin
        tx_next = tx_state;
        tx_pop  = 1'b0;
        tx_wrap = 1'b0;
        txd     = 1'b1;
        case (tx_state)
            TX_IDLE: begin
                if (!tx_empty) begin
                    tx_pop  = 1'b1;
                    tx_next = TX_START;
                end
            end
            TX_START: begin
                txd     = 1'b0;
                tx_wrap = (tx_cnt == tx_bit_end);
                if (tx_wrap) tx_next = TX_DATA;
            end
            TX_DATA: begin
                txd     = tx_shift[0];
                tx_wrap = (tx_cnt == tx_bit_end);
                if (tx_wrap && tx_idx == IDX_LAST) begin
                    if (PARITY != 0) tx_next = TX_PARITY;
                    else             tx_next = TX_STOP;
                end
            end
            TX_PARITY: begin
                txd     = tx_par;
                tx_wrap = (tx_cnt == tx_bit_end);
                if (tx_wrap) tx_next = TX_STOP;
            end
            TX_STOP: begin
                tx_wrap = (tx_cnt == tx_stop_end);
                if (tx_wrap) tx_next = TX_IDLE;
            end
            default: tx_next = TX_IDLE;
        endcase
    end

    // TX bit timer, shift register and per-frame baud latch
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_cnt      <= '0;
            tx_idx      <= '0;
            tx_shift    <= '0;
            tx_par      <= 1'b0;
            tx_bit_end  <= '0;
            tx_stop_end <= '0;
        end else begin
            if (tx_state == TX_IDLE || tx_wrap) tx_cnt <= '0;
            else                                tx_cnt <= tx_cnt + CNT_W'(1);
            if (tx_pop) begin
                tx_shift    <= tx_head;
                tx_par      <= parity_of(tx_head);
                tx_idx      <= '0;
                tx_bit_end  <= cur_div - CNT_W'(1);
                tx_stop_end <= CNT_W'(cur_div * CNT_W'(STOP_BITS)) - CNT_W'(1);
            end else if (tx_state == TX_DATA && tx_wrap) begin
                tx_shift <= tx_shift >> 1;
                tx_idx   <= tx_idx + IDX_W'(1);
            end
        end
    end

    // ---------------- RX path ----------------
    rx_state_t            rx_state, rx_next;
    logic                 rxd_s1, rxd_s2, rxd_prev, rx_fall;
    logic [CNT_W-1:0]     rx_cnt, rx_bit_end, rx_half_end;
    logic [IDX_W-1:0]     rx_idx;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_par_bit, rx_par_bad, rx_sample, rx_stop_done;
    logic                 rx_pop, rx_empty, rx_full, rx_overrun_now;

    assign rx_fall        = rxd_prev && !rxd_s2;
    assign rx_pop         = link.rx_ready && !rx_empty;
    assign link.rx_valid  = !rx_empty;
    assign rx_stop_done   = (rx_state == RX_STOP) && rx_sample;
    assign rx_overrun_now = rx_stop_done && rx_full && !rx_pop;
    assign rx_par_bad     = (PARITY != 0) && (rx_par_bit != parity_of(rx_shift));

    uart_fifo_link_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) rx_fifo (
        .clk(clk), .reset(reset), .push(rx_stop_done), .push_data(rx_shift),
        .pop(rx_pop), .head(link.rx_data), .empty(rx_empty), .full(rx_full)
    );

    // Two-flop synchroniser plus previous-sample flop for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            rxd_s1   <= 1'b1;
            rxd_s2   <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_s1   <= rxd;
            rxd_s2   <= rxd_s1;
            rxd_prev <= rxd_s2;
        end
    end

    // RX state register
    always_ff @(posedge clk) begin
        if (reset) rx_state <= RX_IDLE;
        else       rx_state <= rx_next;
    end

    // RX next state and bit-centre sample strobe
    always_comb begin
        rx_next   = rx_state;
        rx_sample = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (rx_fall) rx_next = RX_START;
            end
            RX_START: begin
                rx_sample = (rx_cnt == rx_half_end);
                if (rx_sample) begin
                    if (rxd_s2) rx_next = RX_IDLE;
                    else        rx_next = RX_DATA;
                end
            end
            RX_DATA: begin
                rx_sample = (rx_cnt == rx_bit_end);
                if (rx_sample && rx_idx == IDX_LAST) begin
                    if (PARITY != 0) rx_next = RX_PARITY;
                    else             rx_next = RX_STOP;
                end
            end
            RX_PARITY: begin
                rx_sample = (rx_cnt == rx_bit_end);
                if (rx_sample) rx_next = RX_STOP;
            end
            RX_STOP: begin
                rx_sample = (rx_cnt == rx_bit_end);
                if (rx_sample) begin
                    if (rxd_s2) rx_next = RX_IDLE;
                    else        rx_next = RX_BREAK;
                end
            end
            RX_BREAK: begin
                if (rxd_s2) rx_next = RX_IDLE;
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    // RX sample timer, data/parity capture and per-frame baud latch
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_cnt      <= '0;
            rx_idx      <= '0;
            rx_shift    <= '0;
            rx_par_bit  <= 1'b0;
            rx_bit_end  <= '0;
            rx_half_end <= '0;
        end else begin
            if (rx_state == RX_IDLE || rx_sample) rx_cnt <= '0;
            else                                  rx_cnt <= rx_cnt + CNT_W'(1);
            if (rx_state == RX_IDLE && rx_fall) begin
                rx_idx      <= '0;
                rx_bit_end  <= cur_div - CNT_W'(1);
                rx_half_end <= (cur_div >> 1) - CNT_W'(1);
            end
            if (rx_state == RX_DATA && rx_sample) begin
                rx_shift <= {rxd_s2, rx_shift[DATA_BITS-1:1]};
                rx_idx   <= rx_idx + IDX_W'(1);
            end
            if (rx_state == RX_PARITY && rx_sample) rx_par_bit <= rxd_s2;
        end
    end

    // Sticky error flags; a new error in the clear cycle keeps the flag set
    always_ff @(posedge clk) begin
        if (reset) begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            parity_err <= (rx_stop_done && rx_par_bad) || (parity_err && !err_clr);
            frame_err  <= (rx_stop_done && !rxd_s2)    || (frame_err && !err_clr);
            overrun    <= rx_overrun_now               || (overrun && !err_clr);
        end
    end
endmodule

// File: tb/tb_uart_fifo_link.sv
// Directed bench for uart_fifo_link: one fast-clock instance for exact bit
// timing at 115200 baud, two slow-clock instances (10 clocks per bit) for
// loopback, parity, framing, overrun, glitch and reset checks.
`timescale 1ns/1ps
module tb_uart_fifo_link;
    localparam int unsigned SLOW_HZ  = 1_152_000;
    localparam int unsigned BIT_CLKS = 10;
    localparam int unsigned FAST_BIT = 868;

    logic       clk;
    logic       reset0, reset1, reset2;
    logic [2:0] baud_sel;
    logic       txd0, txd1, txd2;
    logic       busy0, busy1, busy2;
    logic       rxd0, rxd1, rxd2, rxd1_drv, loop1;
    logic       perr0, perr1, perr2, ferr0, ferr1, ferr2, ovr0, ovr1, ovr2;
    logic       err_clr0, err_clr1, err_clr2;

    int unsigned n_run;
    int unsigned n_fail;

    uart_fifo_link_if #(.DATA_BITS(8)) bus0 ();
    uart_fifo_link_if #(.DATA_BITS(8)) bus1 ();
    uart_fifo_link_if #(.DATA_BITS(8)) bus2 ();

    assign rxd1 = loop1 ? txd1 : rxd1_drv;

    uart_fifo_link u0 (
        .clk(clk), .reset(reset0), .baud_sel(baud_sel), .link(bus0),
        .txd(txd0), .tx_busy(busy0), .rxd(rxd0), .parity_err(perr0),
        .frame_err(ferr0), .overrun(ovr0), .err_clr(err_clr0)
    );

    uart_fifo_link #(.CLK_HZ(SLOW_HZ), .FIFO_DEPTH(16)) u1 (
        .clk(clk), .reset(reset1), .baud_sel(baud_sel), .link(bus1),
        .txd(txd1), .tx_busy(busy1), .rxd(rxd1), .parity_err(perr1),
        .frame_err(ferr1), .overrun(ovr1), .err_clr(err_clr1)
    );

    uart_fifo_link #(.CLK_HZ(SLOW_HZ), .PARITY(2)) u2 (
        .clk(clk), .reset(reset2), .baud_sel(baud_sel), .link(bus2),
        .txd(txd2), .tx_busy(busy2), .rxd(rxd2), .parity_err(perr2),
        .frame_err(ferr2), .overrun(ovr2), .err_clr(err_clr2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // Drive serial bits LSB first onto u1 (which=1) or u2 (which=2)
    task automatic send_bits(input int unsigned which, input logic [15:0] bits, input int unsigned nbits);
        for (int unsigned i = 0; i < nbits; i++) begin
            if (which == 1) rxd1_drv = bits[i];
            else            rxd2     = bits[i];
            tick(BIT_CLKS);
        end
    endtask

    task automatic pop1();
        bus1.rx_ready = 1'b1;
        tick(1);
        bus1.rx_ready = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0]  exp_a5;
        logic [7:0]  exp2 [3];
        logic [7:0]  t5 [17];
        int unsigned acc;

        exp_a5 = {1'b1, 8'hA5, 1'b0};
        exp2   = '{8'h00, 8'hFF, 8'h3C};
        t5     = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                   8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'h0F, 8'hF0, 8'h5A};
        n_run = 0;
        n_fail = 0;
        reset0 = 1'b1; reset1 = 1'b1; reset2 = 1'b1;
        baud_sel = 3'd6;
        loop1 = 1'b0; rxd0 = 1'b1; rxd1_drv = 1'b1; rxd2 = 1'b1;
        err_clr0 = 1'b0; err_clr1 = 1'b0; err_clr2 = 1'b0;
        bus0.tx_valid = 1'b0; bus0.tx_data = '0; bus0.rx_ready = 1'b0;
        bus1.tx_valid = 1'b0; bus1.tx_data = '0; bus1.rx_ready = 1'b0;
        bus2.tx_valid = 1'b0; bus2.tx_data = '0; bus2.rx_ready = 1'b0;
        tick(3);
        reset0 = 1'b0; reset1 = 1'b0; reset2 = 1'b0;

        // Reset state
        check("rst_txd", txd1, 1);
        check("rst_tx_ready", bus1.tx_ready, 1);
        check("rst_tx_busy", busy1, 0);
        check("rst_rx_valid", bus1.rx_valid, 0);
        check("rst_rx_data", bus1.rx_data, 0);
        check("rst_flags", {perr1, ferr1, ovr1}, 0);
        check("rst_txd_fast", txd0, 1);
        check("rst_rx_valid_par", bus2.rx_valid, 0);

        // 0xA5 at 868 clocks per bit
        bus0.tx_data = 8'hA5;
        bus0.tx_valid = 1'b1;
        tick(1);
        bus0.tx_valid = 1'b0;
        check("t1_txd_before_pop", txd0, 1);
        check("t1_busy_queued", busy0, 1);
        tick(1);
        for (int unsigned k = 0; k < 10; k++) begin
            check($sformatf("t1_bit%0d_first", k), txd0, exp_a5[k]);
            tick(FAST_BIT - 1);
            check($sformatf("t1_bit%0d_last", k), txd0, exp_a5[k]);
            tick(1);
        end
        check("t1_idle_txd", txd0, 1);
        check("t1_idle_busy", busy0, 0);

        // Loopback of three back-to-back bytes
        loop1 = 1'b1;
        bus1.tx_valid = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            bus1.tx_data = exp2[i];
            tick(1);
        end
        bus1.tx_valid = 1'b0;
        tick(400);
        check("t2_flags", {perr1, ferr1, ovr1}, 0);
        for (int unsigned i = 0; i < 3; i++) begin
            check($sformatf("t2_valid%0d", i), bus1.rx_valid, 1);
            check($sformatf("t2_data%0d", i), bus1.rx_data, exp2[i]);
            pop1();
        end
        check("t2_empty", bus1.rx_valid, 0);
        loop1 = 1'b0;

        // One-clock low glitch
        rxd1_drv = 1'b0;
        tick(1);
        rxd1_drv = 1'b1;
        tick(60);
        check("t6_glitch_no_push", bus1.rx_valid, 0);
        check("t6_glitch_flags", {perr1, ferr1, ovr1}, 0);

        // 0x55 with stop bit low; err_clr lands on the stop-sample cycle
        send_bits(1, {7'b0, 8'h55, 1'b0}, 9);
        rxd1_drv = 1'b0;
        tick(7);
        err_clr1 = 1'b1;
        tick(1);
        err_clr1 = 1'b0;
        check("t4_ferr_new_wins", ferr1, 1);
        check("t4_pushed", bus1.rx_valid, 1);
        check("t4_data", bus1.rx_data, 8'h55);
        check("t4_perr", perr1, 0);
        tick(30);
        check("t4_ferr_sticky", ferr1, 1);
        rxd1_drv = 1'b1;
        tick(20);
        pop1();
        check("t4_break_no_extra", bus1.rx_valid, 0);
        err_clr1 = 1'b1;
        tick(1);
        err_clr1 = 1'b0;
        check("t4_ferr_cleared", ferr1, 0);
        send_bits(1, {1'b1, 8'h12, 1'b0}, 10);
        tick(2);
        check("t4_after_break_valid", bus1.rx_valid, 1);
        check("t4_after_break_data", bus1.rx_data, 8'h12);
        check("t4_after_break_ferr", ferr1, 0);
        pop1();

        // Parity: 0x01 sent with even-parity bit 0 (should be 1)
        send_bits(2, {5'b0, 1'b1, 1'b0, 8'h01, 1'b0}, 11);
        tick(2);
        check("t3_valid", bus2.rx_valid, 1);
        check("t3_data", bus2.rx_data, 8'h01);
        check("t3_perr", perr2, 1);
        check("t3_ferr", ferr2, 0);
        err_clr2 = 1'b1;
        tick(1);
        err_clr2 = 1'b0;
        check("t3_perr_cleared", perr2, 0);
        bus2.rx_ready = 1'b1;
        tick(1);
        bus2.rx_ready = 1'b0;
        send_bits(2, {5'b0, 1'b1, 1'b0, 8'h03, 1'b0}, 11);
        tick(2);
        check("t3_good_data", bus2.rx_data, 8'h03);
        check("t3_good_perr", perr2, 0);

        // RX overrun: 17 frames with no pops
        for (int unsigned i = 0; i < 17; i++) begin
            send_bits(1, {6'b0, 1'b1, t5[i], 1'b0}, 10);
            if (i == 15) check("t5_no_overrun_at_16", ovr1, 0);
        end
        check("t5_overrun", ovr1, 1);
        check("t5_other_flags", {perr1, ferr1}, 0);
        for (int unsigned i = 0; i < 16; i++) begin
            check($sformatf("t5_data%0d", i), bus1.rx_data, t5[i]);
            pop1();
        end
        check("t5_17th_dropped", bus1.rx_valid, 0);
        err_clr1 = 1'b1;
        tick(1);
        err_clr1 = 1'b0;
        check("t5_overrun_cleared", ovr1, 0);

        // TX FIFO fill: 17 accepted (one popped immediately), extra pushes ignored
        acc = 0;
        bus1.tx_data = 8'h00;
        bus1.tx_valid = 1'b1;
        for (int unsigned i = 0; i < 20; i++) begin
            if (bus1.tx_ready) acc++;
            tick(1);
        end
        bus1.tx_valid = 1'b0;
        check("t6_tx_accepted", acc, 17);
        check("t6_tx_full", bus1.tx_ready, 0);
        tick(30);
        check("t6_mid_frame_low", txd1, 0);
        reset1 = 1'b1;
        tick(1);
        reset1 = 1'b0;
        check("t6_reset_txd", txd1, 1);
        check("t6_reset_ready", bus1.tx_ready, 1);
        check("t6_reset_busy", busy1, 0);
        tick(150);
        check("t6_stays_idle", txd1, 1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
